// File: rtl/input_conditioner.sv
// Per-channel conditioning of slow asynchronous control inputs in the clk27 domain:
// synchronizer, polarity fix, debounce, edge pulses, LED stretcher, sticky flag and rise counter.
module input_conditioner #(
  parameter int unsigned          NUM_CH          = 4,
  parameter int unsigned          SYNC_STAGES     = 2,
  parameter int unsigned          DEBOUNCE_CYCLES = 270000,
  parameter int unsigned          STRETCH_CYCLES  = 16777215,
  parameter logic [NUM_CH-1:0]    INVERT_MASK     = '0
) (
  input  logic                  clk27,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     in_i,
  input  logic [NUM_CH-1:0]     evt_clr_i,
  output logic [NUM_CH-1:0]     stable_o,
  output logic [NUM_CH-1:0]     rise_o,
  output logic [NUM_CH-1:0]     fall_o,
  output logic [NUM_CH-1:0]     stretch_o,
  output logic [NUM_CH-1:0]     evt_o,
  output logic [NUM_CH*8-1:0]   evt_cnt_o
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned SW = $clog2(STRETCH_CYCLES + 1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          db_cnt;
    logic [SW-1:0]          st_cnt;
    logic                   stable_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   evt_q;
    logic [7:0]             cnt_q;
    logic                   s;
    logic                   mism;
    logic                   accept;
    logic                   rise_dec;

    // Chain idles at the pin's inactive level so reset release produces no edge
    assign s        = sync_q[SYNC_STAGES-1] ^ INVERT_MASK[i];
    assign mism     = (s != stable_q);
    assign accept   = mism && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign rise_dec = accept && s;

    always_ff @(posedge clk27) begin
      if (reset) begin
        sync_q   <= {SYNC_STAGES{INVERT_MASK[i]}};
        db_cnt   <= '0;
        st_cnt   <= '0;
        stable_q <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        evt_q    <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], in_i[i]};

        if (accept) begin
          stable_q <= s;
          db_cnt   <= '0;
        end else if (mism) begin
          db_cnt <= db_cnt + DW'(1);
        end else begin
          db_cnt <= '0;
        end

        rise_q <= rise_dec;
        fall_q <= accept && !s;

        if (rise_dec)
          st_cnt <= SW'(STRETCH_CYCLES);
        else if (st_cnt != '0)
          st_cnt <= st_cnt - SW'(1);

        // A clear in the same cycle as a rise loses to the set
        if (rise_dec)
          evt_q <= 1'b1;
        else if (evt_clr_i[i])
          evt_q <= 1'b0;

        if (rise_dec)
          cnt_q <= cnt_q + 8'd1;
      end
    end

    assign stable_o[i]        = stable_q;
    assign rise_o[i]          = rise_q;
    assign fall_o[i]          = fall_q;
    assign stretch_o[i]       = (st_cnt != '0);
    assign evt_o[i]           = evt_q;
    assign evt_cnt_o[8*i +: 8] = cnt_q;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed phases plus random pin activity, checked every cycle
// against a history-based reference model.
module tb_input_conditioner;

  localparam int NCH = 2;
  localparam int SS  = 2;
  localparam int DB  = 4;
  localparam int ST  = 8;
  localparam logic [NCH-1:0] INV = 2'b01;

  logic             clk27 = 1'b0;
  logic             reset;
  logic [NCH-1:0]   in_i;
  logic [NCH-1:0]   evt_clr_i;
  logic [NCH-1:0]   stable_o, rise_o, fall_o, stretch_o, evt_o;
  logic [NCH*8-1:0] evt_cnt_o;

  always #5 clk27 = ~clk27;

  input_conditioner #(
    .NUM_CH(NCH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .STRETCH_CYCLES(ST), .INVERT_MASK(INV)
  ) dut (
    .clk27(clk27), .reset(reset), .in_i(in_i), .evt_clr_i(evt_clr_i),
    .stable_o(stable_o), .rise_o(rise_o), .fall_o(fall_o),
    .stretch_o(stretch_o), .evt_o(evt_o), .evt_cnt_o(evt_cnt_o)
  );

  int total = 0;
  int bad   = 0;
  int k     = 0;

  // Reference model: pin delay line, history of synchronized levels, and event bookkeeping
  bit pipe   [NCH][SS];
  bit shist  [NCH][DB];
  bit m_stable[NCH], m_rise[NCH], m_fall[NCH], m_evt[NCH], rise_seen[NCH];
  int m_cnt  [NCH];
  int last_flip[NCH], last_rise[NCH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic model_edge();
    bit s, all_diff;
    k++;
    for (int i = 0; i < NCH; i++) begin
      if (reset) begin
        for (int j = 0; j < SS; j++) pipe[i][j] = INV[i];
        m_stable[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_evt[i] = 0;
        m_cnt[i] = 0; rise_seen[i] = 0; last_flip[i] = k;
      end else begin
        s = pipe[i][0] ^ INV[i];
        for (int j = 0; j < SS-1; j++) pipe[i][j] = pipe[i][j+1];
        pipe[i][SS-1] = in_i[i];
        for (int j = DB-1; j > 0; j--) shist[i][j] = shist[i][j-1];
        shist[i][0] = s;
        all_diff = 1;
        for (int j = 0; j < DB; j++) if (shist[i][j] == m_stable[i]) all_diff = 0;
        // New level accepted once it has disagreed on every one of the last DB edges since the last change
        if (all_diff && (k - last_flip[i]) >= DB) begin
          m_stable[i] = !m_stable[i];
          last_flip[i] = k;
          m_rise[i] = m_stable[i];
          m_fall[i] = !m_stable[i];
        end else begin
          m_rise[i] = 0; m_fall[i] = 0;
        end
        if (m_rise[i]) begin
          m_evt[i] = 1; m_cnt[i] = (m_cnt[i] + 1) % 256;
          last_rise[i] = k; rise_seen[i] = 1;
        end else if (evt_clr_i[i]) begin
          m_evt[i] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk27);
    model_edge();
    @(negedge clk27);
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("stable%0d", i),  32'(stable_o[i]),  32'(m_stable[i]));
      chk($sformatf("rise%0d", i),    32'(rise_o[i]),    32'(m_rise[i]));
      chk($sformatf("fall%0d", i),    32'(fall_o[i]),    32'(m_fall[i]));
      chk($sformatf("stretch%0d", i), 32'(stretch_o[i]),
          32'(rise_seen[i] && (k - last_rise[i]) < ST));
      chk($sformatf("evt%0d", i),     32'(evt_o[i]),     32'(m_evt[i]));
      chk($sformatf("cnt%0d", i),     32'(evt_cnt_o[8*i +: 8]), 32'(m_cnt[i]));
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) tick();
  endtask

  initial begin
    int hold;
    int saved_cnt;
    reset = 1'b1; in_i = 2'b01; evt_clr_i = 2'b00;
    for (int i = 0; i < NCH; i++) begin
      last_rise[i] = 0;
      for (int j = 0; j < DB; j++) shist[i][j] = 0;
    end
    @(negedge clk27);

    // Reset with idle pins, then quiet operation
    run(3);
    reset = 1'b0;
    run(50);
    chk("idle_stable", 32'(stable_o), 32'(0));
    chk("idle_evt",    32'(evt_o),    32'(0));

    // Clean press on ch1: accepted on the sixth edge after the pin change
    in_i = 2'b11;
    run(5);
    chk("press_early", 32'(stable_o[1]), 32'(0));
    tick();
    chk("press_stable", 32'(stable_o[1]), 32'(1));
    chk("press_rise",   32'(rise_o[1]),   32'(1));
    run(12);
    chk("press_cnt", 32'(evt_cnt_o[15:8]), 32'(1));
    in_i = 2'b01;
    run(10);

    // Glitch of 3 cycles rejected, 4 cycles accepted
    in_i = 2'b11; run(3); in_i = 2'b01; run(12);
    chk("glitch_cnt", 32'(evt_cnt_o[15:8]), 32'(1));
    in_i = 2'b11; run(4); in_i = 2'b01; run(14);
    chk("pulse4_cnt", 32'(evt_cnt_o[15:8]), 32'(2));

    // Active-low ch0 press and release
    in_i = 2'b00; run(12); in_i = 2'b01; run(12);
    chk("ch0_evt", 32'(evt_o[0]), 32'(1));

    // Clear coinciding with the rise, then clear alone
    in_i = 2'b11; run(5); evt_clr_i = 2'b10; tick(); evt_clr_i = 2'b00;
    chk("clr_vs_rise", 32'(evt_o[1]), 32'(1));
    run(3); evt_clr_i = 2'b10; tick(); evt_clr_i = 2'b00;
    chk("clr_alone", 32'(evt_o[1]), 32'(0));
    in_i = 2'b01; run(6);
    in_i = 2'b11; run(6); in_i = 2'b01; run(6); in_i = 2'b11; run(8);
    in_i = 2'b01; run(12);

    // 256 presses wrap the counter back to its starting value
    saved_cnt = m_cnt[1];
    for (int n = 0; n < 256; n++) begin
      in_i = 2'b11; run(7);
      in_i = 2'b01; run(7);
    end
    chk("wrap_cnt", 32'(evt_cnt_o[15:8]), 32'(saved_cnt));

    // Reset during a debounce count, then during a stretch
    in_i = 2'b11; run(4); reset = 1'b1; tick(); in_i = 2'b01; reset = 1'b0;
    chk("rst_db_cnt", 32'(evt_cnt_o), 32'(0));
    run(15);
    in_i = 2'b11; run(9); reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_st_stretch", 32'(stretch_o), 32'(0));
    in_i = 2'b01; run(15);

    // Random pin activity with random clears and rare resets
    hold = 0;
    for (int n = 0; n < 1500; n++) begin
      if (hold == 0) begin
        in_i = 2'($urandom_range(0, 3));
        hold = $urandom_range(1, 8);
      end
      hold--;
      evt_clr_i[0] = ($urandom_range(0, 7) == 0);
      evt_clr_i[1] = ($urandom_range(0, 7) == 0);
      reset        = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; evt_clr_i = 2'b00;
    run(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
